mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl_pkg.sv | 28 ++
 rtl/mdu_ctrl_if.sv | 22 ++
 rtl/mdu_ctrl_div_core.sv | 61 ++++++
 rtl/mdu_ctrl.sv | 158 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings, FSM states, operand helpers.
package mdu_ctrl_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } mdu_state_e;

   function automatic logic [31:0] abs32(
      input logic [31:0] v,
      input logic        sgn
   );
      return (sgn && v[31]) ? 32'd0 - v : v;
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU request/result bundle.
interface mdu_ctrl_if;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
      input  stall, busy, hi, lo
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
      output stall, busy, hi, lo
   );
endinterface

// File: rtl/mdu_ctrl_div_core.sv
// Iterative restoring divider on magnitudes, one quotient bit per cycle.
module mdu_ctrl_div_core
   import mdu_ctrl_pkg::*;
#(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        kill,
   input  logic        sgn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] quo,
   output logic [31:0] rem,
   output logic        done
);

   logic        run;
   logic [4:0]  cnt;
   logic [31:0] q;
   logic [31:0] d;
   logic [32:0] r;
   logic [33:0] diff;

   // trial subtraction of divisor from shifted partial remainder
   assign diff = {r, q[31]} - {2'b00, d};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run <= 1'b0;
         cnt <= 5'd0;
         q   <= 32'd0;
         d   <= 32'd0;
         r   <= 33'd0;
      end else if (kill) begin
         run <= 1'b0;
      end else if (start) begin
         run <= 1'b1;
         cnt <= 5'(ITER - 1);
         q   <= abs32(a, sgn);
         d   <= abs32(b, sgn);
         r   <= 33'd0;
      end else if (run) begin
         if (!diff[33]) begin
            r <= diff[32:0];
            q <= {q[30:0], 1'b1};
         end else begin
            r <= {r[31:0], q[31]};
            q <= {q[30:0], 1'b0};
         end
         if (cnt == 5'd0) run <= 1'b0;
         else             cnt <= cnt - 5'd1;
      end
   end

   assign done = run && (cnt == 5'd0);
   assign quo  = q;
   assign rem  = r[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: multiply, divide, HI/LO and pipeline stall.
// Optional: MDU_DIVZERO_FAST_EN short-cuts divide-by-zero.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_ITER   = 32
) (
   input logic       clk,
   input logic       resetn,
   mdu_ctrl_if.slave mdu
);

   mdu_state_e  state;
   mdu_state_e  nxt;
   logic [4:0]  cnt;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [32:0] ma;
   logic [32:0] mb;
   logic        qneg;
   logic        aneg;
   logic        dz;
   logic        dz_q;
   logic        is_mul;
   logic        is_div;
   logic        is_mthi;
   logic        is_mtlo;
   logic        sgn;
   logic        idle_req;
   logic        acc;
   logic [63:0] xa;
   logic [63:0] xb;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        div_done;

   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      is_mthi = 1'b0;
      is_mtlo = 1'b0;
      sgn     = 1'b0;
      unique case (mdu.req_op)
         MDU_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
         MDU_MULTU: is_mul = 1'b1;
         MDU_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
         MDU_DIVU:  is_div = 1'b1;
         MDU_MTHI:  is_mthi = 1'b1;
         MDU_MTLO:  is_mtlo = 1'b1;
         default:   ;
      endcase
   end

`ifdef MDU_DIVZERO_FAST_EN
   assign dz = is_div && (mdu.req_b == 32'd0);
`else
   assign dz = 1'b0;
`endif

   assign idle_req = (state == S_IDLE) && mdu.req_valid && !mdu.flush;
   assign acc      = idle_req && (is_mul || is_div);

   // low 64 bits of the 33x33 signed product
   assign xa   = {{31{ma[32]}}, ma};
   assign xb   = {{31{mb[32]}}, mb};
   assign prod = xa * xb;

   mdu_ctrl_div_core #(
      .ITER (DIV_ITER)
   ) u_div (
      .clk    (clk),
      .resetn (resetn),
      .start  (acc && is_div && !dz),
      .kill   (mdu.flush),
      .sgn    (sgn),
      .a      (mdu.req_a),
      .b      (mdu.req_b),
      .quo    (quo),
      .rem    (rem),
      .done   (div_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (mdu.flush) begin
         nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: if (acc) nxt = is_mul ? S_MUL : (dz ? S_FIX : S_DIV);
            S_MUL:  if (cnt == 5'd0) nxt = S_DONE;
            S_DIV:  if (div_done) nxt = S_FIX;
            S_FIX:  nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mdu.busy  = (state != S_IDLE);
      mdu.stall = acc
         || (!mdu.flush
             && (state == S_MUL || state == S_DIV || state == S_FIX));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
         cnt  <= 5'd0;
         ma   <= 33'd0;
         mb   <= 33'd0;
         qneg <= 1'b0;
         aneg <= 1'b0;
         dz_q <= 1'b0;
      end else if (!mdu.flush) begin
         unique case (state)
            S_IDLE: begin
               if (idle_req && is_mthi) hi_q <= mdu.req_a;
               if (idle_req && is_mtlo) lo_q <= mdu.req_a;
               if (acc) begin
                  cnt  <= 5'(MUL_CYCLES - 1);
                  ma   <= {sgn & mdu.req_a[31], mdu.req_a};
                  mb   <= {sgn & mdu.req_b[31], mdu.req_b};
                  qneg <= sgn & (mdu.req_a[31] ^ mdu.req_b[31]);
                  aneg <= sgn & mdu.req_a[31];
                  dz_q <= dz;
               end
            end
            S_MUL: begin
               if (cnt == 5'd0) {hi_q, lo_q} <= prod;
               else             cnt <= cnt - 5'd1;
            end
            S_FIX: begin
               if (dz_q) begin
                  hi_q <= ma[31:0];
                  lo_q <= 32'hFFFF_FFFF;
               end else begin
                  lo_q <= qneg ? 32'd0 - quo : quo;
                  hi_q <= aneg ? 32'd0 - rem : rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign mdu.hi = hi_q;
   assign mdu.lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl.
module tb_mdu_ctrl;

   typedef struct {
      string       tag;
      int          stl;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        busy;
   } exp_t;

   logic clk;
   logic resetn;
   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   mdu_ctrl_if bus ();

   mdu_ctrl #(
      .MUL_CYCLES (2),
      .DIV_ITER   (32)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .mdu    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(
      input string       tag,
      input logic [2:0]  op,
      input logic [31:0] a,
      input logic [31:0] b,
      input int          stl,
      input logic [31:0] ehi,
      input logic [31:0] elo
   );
      exp_t e;
      int   cyc;
      sb.push_back('{tag, stl, ehi, elo, op <= 3'd3});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      cyc = 0;
      @(negedge clk);
      while (bus.stall === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      e = sb.pop_front();
      chk({e.tag, " stall"}, 32'(cyc), 32'(e.stl));
      chk({e.tag, " busy"}, 32'(bus.busy), 32'(e.busy));
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk({e.tag, " hi"}, bus.hi, e.hi);
      chk({e.tag, " lo"}, bus.lo, e.lo);
      chk({e.tag, " idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int dz_stl;
      resetn        = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.flush     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst hi", bus.hi, 32'd0);
      chk("rst lo", bus.lo, 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst stall", 32'(bus.stall), 32'd0);
      resetn = 1'b1;

      run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3,
             3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             3, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2,
             34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", 3'd3, 32'd100, 32'd7,
             34, 32'd2, 32'd14);
      run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
             34, 32'd0, 32'h8000_0000);
      run_op("div mix", 3'd2, 32'd7, 32'hFFFF_FFFE,
             34, 32'd1, 32'hFFFF_FFFD);
`ifdef MDU_DIVZERO_FAST_EN
      dz_stl = 2;
`else
      dz_stl = 34;
`endif
      run_op("div zero", 3'd2, 32'd5, 32'd0,
             dz_stl, 32'd5, 32'hFFFF_FFFF);

      // flush ten cycles into a divide, then MTHI
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd3;
      bus.req_a     = 32'd100;
      bus.req_b     = 32'd7;
      repeat (10) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(negedge clk);
      chk("flush stall", 32'(bus.stall), 32'd0);
      chk("flush busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      bus.flush  = 1'b0;
      bus.req_op = 3'd4;
      bus.req_a  = 32'h1234;
      @(negedge clk);
      chk("flush hi", bus.hi, 32'd5);
      chk("flush lo", bus.lo, 32'hFFFF_FFFF);
      chk("mthi stall", 32'(bus.stall), 32'd0);
      chk("flush idle", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("mthi hi", bus.hi, 32'h1234);

      // MT write suppressed by a concurrent flush
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd5;
      bus.req_a     = 32'hABCD;
      bus.flush     = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      @(negedge clk);
      chk("mtlo flushed", bus.lo, 32'hFFFF_FFFF);

      run_op("mtlo", 3'd5, 32'hABCD, 32'd0,
             0, 32'h1234, 32'hABCD);
      run_op("noop", 3'd6, 32'hDEAD, 32'hBEEF,
             0, 32'h1234, 32'hABCD);

      // asynchronous reset in the middle of a divide
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd3;
      bus.req_a     = 32'd100;
      bus.req_b     = 32'd7;
      repeat (5) @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      #1;
      chk("pre-rst busy", 32'(bus.busy), 32'd1);
      resetn = 1'b0;
      #1;
      chk("mid-rst busy", 32'(bus.busy), 32'd0);
      chk("mid-rst hi", bus.hi, 32'd0);
      chk("mid-rst lo", bus.lo, 32'd0);
      chk("mid-rst stall", 32'(bus.stall), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("post-rst busy", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
